// File: rtl/cpu_pkg.sv
// Shared definitions for the lab CPU and its instruction issuer: instruction
// kinds, opcode/ALUop field constants and the issuer FSM state encoding.
package cpu_pkg;

  // Instruction kinds as presented by host logic; codes 6 and 7 are illegal.
  typedef enum logic [2:0] {
    K_MOV_IMM = 3'd0,
    K_MOV_REG = 3'd1,
    K_ADD     = 3'd2,
    K_CMP     = 3'd3,
    K_AND     = 3'd4,
    K_MVN     = 3'd5
  } instr_kind_t;

  // Top three bits of the instruction word.
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // Sub-op field for the MOV group.
  localparam logic [1:0] MOV_SUB_IMM = 2'b10;
  localparam logic [1:0] MOV_SUB_REG = 2'b00;

  // ALUop field for the ALU group.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // Issue FSM states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4,
    S_HALT    = 3'd5
  } issuer_state_t;

endpackage

// File: rtl/instr_encoder.sv
// Combinational encoder: decoded instruction fields -> 16-bit CPU instruction
// word, plus a legal flag that is low for the two unused kind codes.
module instr_encoder
  import cpu_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [2:0]  rn_i,
  input  logic [2:0]  rd_i,
  input  logic [2:0]  rm_i,
  input  logic [1:0]  shift_i,
  input  logic [7:0]  imm8_i,
  output logic [15:0] word_o,
  output logic        legal_o
);

  // Pack fields per kind; CMP has no destination and MVN has no first operand,
  // so those fields are forced to zero rather than passed through.
  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (kind_i)
      K_MOV_IMM: word_o = {OP_MOV, MOV_SUB_IMM, rn_i, imm8_i};
      K_MOV_REG: word_o = {OP_MOV, MOV_SUB_REG, 3'b000, rd_i, shift_i, rm_i};
      K_ADD:     word_o = {OP_ALU, ALU_ADD, rn_i, rd_i, shift_i, rm_i};
      K_CMP:     word_o = {OP_ALU, ALU_CMP, rn_i, 3'b000, shift_i, rm_i};
      K_AND:     word_o = {OP_ALU, ALU_AND, rn_i, rd_i, shift_i, rm_i};
      K_MVN:     word_o = {OP_ALU, ALU_MVN, 3'b000, rd_i, shift_i, rm_i};
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer for the lab CPU: encodes host instructions, buffers them
// in a small FIFO and drives the CPU load/start handshake, waiting on cpu_w.
//
// Handshakes: the host side is valid/ready -- an instruction transfers on a
// rising clk edge where enq_valid && enq_ready; enq_valid may be held while
// enq_ready is low and fields must stay stable until the transfer. The CPU
// side is load (one cycle), start (one cycle), then cpu_w must fall and rise
// again to signal completion; TIMEOUT bounds that wait.
module instr_issuer
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [2:0]    kind,
  input  logic [2:0]    rn,
  input  logic [2:0]    rd,
  input  logic [2:0]    rm,
  input  logic [1:0]    shift,
  input  logic [7:0]    imm8,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  input  logic          cpu_w,
  output logic [7:0]    issued_count,
  output logic          busy,
  output logic          err,
  output logic          bad_cmd,
  output issuer_state_t dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  logic [15:0]   enc_word;
  logic          enc_legal;

  logic [15:0]   mem_q [DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          empty, full;
  logic          offer, push, pop;

  issuer_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic [7:0]    issued_count_q, issued_count_d;
  logic          err_q, err_d;
  logic          bad_cmd_q, bad_cmd_d;

  instr_encoder u_enc (
    .kind_i  (kind),
    .rn_i    (rn),
    .rd_i    (rd),
    .rm_i    (rm),
    .shift_i (shift),
    .imm8_i  (imm8),
    .word_o  (enc_word),
    .legal_o (enc_legal)
  );

  // Pointers carry one extra wrap bit: equal -> empty, only MSB differs -> full.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign enq_ready = !full && (state_q != S_HALT);
  assign offer     = enq_valid && enq_ready;
  assign push      = offer && enc_legal;
  assign timer_inc = timer_q + TW'(1);

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= enc_word;
  end

  // Issue FSM next state, timeout timer and pop decision.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE:    if (!empty && cpu_w) state_d = S_LOAD;
      S_LOAD:    state_d = S_START;
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        timer_d = timer_inc;
        if (timer_inc == TW'(TIMEOUT)) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else if (!cpu_w) begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        timer_d = timer_inc;
        // Completion on the last allowed cycle still counts as success.
        if (cpu_w) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end else if (timer_inc == TW'(TIMEOUT)) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values for pointers, completion counter and the bad-kind pulse.
  always_comb begin
    wr_ptr_d       = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d       = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    issued_count_d = pop  ? issued_count_q + 8'd1 : issued_count_q;
    bad_cmd_d      = offer && !enc_legal;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      issued_count_q <= '0;
      err_q          <= 1'b0;
      bad_cmd_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      issued_count_q <= issued_count_d;
      err_q          <= err_d;
      bad_cmd_q      <= bad_cmd_d;
    end
  end

  // Moore outputs decoded from the state register and FIFO head.
  always_comb begin
    cpu_load = (state_q == S_LOAD);
    cpu_s    = (state_q == S_START);
    cpu_in   = '0;
    if (state_q == S_LOAD || state_q == S_START) cpu_in = mem_q[rd_ptr_q[PW-1:0]];
  end

  assign issued_count = issued_count_q;
  assign busy         = (state_q != S_IDLE) || !empty;
  assign err          = err_q;
  assign bad_cmd      = bad_cmd_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed testbench for instr_issuer: encoding, issue handshake timing,
// FIFO back-pressure and ordering, illegal kinds, timeout fault and reset.
module tb_instr_issuer;
  import cpu_pkg::*;

  logic          clk;
  logic          reset;
  logic          enq_valid;
  logic          enq_ready;
  logic [2:0]    kind, rn, rd, rm;
  logic [1:0]    shift;
  logic [7:0]    imm8;
  logic [15:0]   cpu_in;
  logic          cpu_load, cpu_s, cpu_w;
  logic [7:0]    issued_count;
  logic          busy, err, bad_cmd;
  issuer_state_t dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  instr_issuer #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .kind         (kind),
    .rn           (rn),
    .rd           (rd),
    .rm           (rm),
    .shift        (shift),
    .imm8         (imm8),
    .cpu_in       (cpu_in),
    .cpu_load     (cpu_load),
    .cpu_s        (cpu_s),
    .cpu_w        (cpu_w),
    .issued_count (issued_count),
    .busy         (busy),
    .err          (err),
    .bad_cmd      (bad_cmd),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one instruction for exactly one edge; ready is expected high.
  task automatic enq(input logic [2:0] k, input logic [2:0] n, input logic [2:0] d,
                     input logic [2:0] m, input logic [1:0] sh, input logic [7:0] im);
    kind = k; rn = n; rd = d; rm = m; shift = sh; imm8 = im;
    enq_valid = 1'b1;
    chk("enq_ready_pre", 32'(enq_ready), 32'd1);
    tick();
    enq_valid = 1'b0;
  endtask

  // Wait (bounded) for the LOAD cycle.
  task automatic wait_load();
    for (int i = 0; i < 20 && !cpu_load; i++) tick();
    chk("load_seen", 32'(cpu_load), 32'd1);
  endtask

  // CPU model: observe load/start for the expected word, then toggle cpu_w 1->0->1.
  task automatic run_cpu(input string tag, input logic [15:0] exp_word);
    wait_load();
    chk({tag, "_load_word"}, 32'(cpu_in), 32'(exp_word));
    chk({tag, "_load_no_s"}, 32'(cpu_s), 32'd0);
    tick();
    chk({tag, "_start_s"}, 32'(cpu_s), 32'd1);
    chk({tag, "_start_no_load"}, 32'(cpu_load), 32'd0);
    chk({tag, "_start_word"}, 32'(cpu_in), 32'(exp_word));
    tick();
    chk({tag, "_wait_quiet"}, 32'({cpu_load, cpu_s}), 32'd0);
    chk({tag, "_wait_in_zero"}, 32'(cpu_in), 32'd0);
    cpu_w = 1'b0;
    tick();
    cpu_w = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; enq_valid = 1'b0; cpu_w = 1'b1;
    kind = '0; rn = '0; rd = '0; rm = '0; shift = '0; imm8 = '0;

    // Reset values
    tick(); tick();
    reset = 1'b1;
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_cpu_in", 32'(cpu_in), 32'd0);
    chk("rst_load_s", 32'({cpu_load, cpu_s}), 32'd0);
    chk("rst_count", 32'(issued_count), 32'd0);
    chk("rst_err_bad", 32'({err, bad_cmd}), 32'd0);
    chk("rst_ready", 32'(enq_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // MOV_IMM rn=0 imm8=7: exact issue latency from the accept edge
    enq(K_MOV_IMM, 3'd0, 3'd0, 3'd0, 2'd0, 8'd7);
    chk("t1_e0_load", 32'(cpu_load), 32'd0);
    chk("t1_e0_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_e1_load", 32'(cpu_load), 32'd1);
    chk("t1_e1_s", 32'(cpu_s), 32'd0);
    chk("t1_e1_word", 32'(cpu_in), 32'h0000_D007);
    tick();
    chk("t1_e2_load", 32'(cpu_load), 32'd0);
    chk("t1_e2_s", 32'(cpu_s), 32'd1);
    chk("t1_e2_word", 32'(cpu_in), 32'h0000_D007);
    tick();
    chk("t1_e3_quiet", 32'({cpu_load, cpu_s}), 32'd0);
    chk("t1_e3_state", 32'(dbg_state), 32'(S_WAIT_LO));
    cpu_w = 1'b0;
    tick();
    chk("t1_wait_hi", 32'(dbg_state), 32'(S_WAIT_HI));
    cpu_w = 1'b1;
    tick();
    chk("t1_count", 32'(issued_count), 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // ALU encodings with forced-zero fields; fills the FIFO exactly
    cpu_w = 1'b0;
    enq(K_ADD, 3'd1, 3'd2, 3'd3, 2'd0, 8'd0);
    enq(K_CMP, 3'd1, 3'd6, 3'd3, 2'd0, 8'd0);
    enq(K_MVN, 3'd5, 3'd2, 3'd3, 2'd1, 8'd0);
    enq(K_AND, 3'd7, 3'd5, 3'd6, 2'd2, 8'd0);
    chk("t2_full_ready", 32'(enq_ready), 32'd0);
    chk("t2_idle_w0", 32'(dbg_state), 32'(S_IDLE));
    cpu_w = 1'b1;
    run_cpu("t2_add", 16'hA143);
    run_cpu("t2_cmp", 16'hA903);
    run_cpu("t2_mvn", 16'hB84B);
    run_cpu("t2_and", 16'hB7B6);
    chk("t2_count", 32'(issued_count), 32'd5);

    // Back-pressure: 5 MOV_REG offers with cpu_w held low
    cpu_w = 1'b0;
    enq(K_MOV_REG, 3'd0, 3'd1, 3'd1, 2'd0, 8'd0);
    enq(K_MOV_REG, 3'd0, 3'd2, 3'd2, 2'd0, 8'd0);
    enq(K_MOV_REG, 3'd0, 3'd3, 3'd3, 2'd0, 8'd0);
    enq(K_MOV_REG, 3'd0, 3'd4, 3'd4, 2'd0, 8'd0);
    chk("t3_ready_after4", 32'(enq_ready), 32'd0);
    kind = K_MOV_REG; rn = 3'd0; rd = 3'd5; rm = 3'd5; shift = 2'd0;
    enq_valid = 1'b1;
    tick(); tick();
    chk("t3_held_ready", 32'(enq_ready), 32'd0);
    chk("t3_held_busy", 32'(busy), 32'd1);
    cpu_w = 1'b1;
    run_cpu("t3_i1", 16'hC021);
    chk("t3_ready_after_pop", 32'(enq_ready), 32'd1);
    tick();
    enq_valid = 1'b0;
    run_cpu("t3_i2", 16'hC042);
    run_cpu("t3_i3", 16'hC063);
    run_cpu("t3_i4", 16'hC084);
    run_cpu("t3_i5", 16'hC0A5);
    chk("t3_count", 32'(issued_count), 32'd10);
    chk("t3_idle_busy", 32'(busy), 32'd0);

    // Illegal kind
    enq(3'd6, 3'd1, 3'd1, 3'd1, 2'd0, 8'd0);
    chk("t4_bad_pulse", 32'(bad_cmd), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    tick();
    chk("t4_bad_clear", 32'(bad_cmd), 32'd0);
    chk("t4_busy2", 32'(busy), 32'd0);
    chk("t4_count", 32'(issued_count), 32'd10);

    // Timeout: CPU never completes
    enq(K_MOV_IMM, 3'd5, 3'd0, 3'd0, 2'd0, 8'hAA);
    wait_load();
    chk("t5_word", 32'(cpu_in), 32'h0000_D5AA);
    tick();
    chk("t5_start", 32'(cpu_s), 32'd1);
    cpu_w = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("t5_err_early", 32'(err), 32'd0);
    chk("t5_not_halt_early", 32'(dbg_state), 32'(S_WAIT_HI));
    tick();
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_halt", 32'(dbg_state), 32'(S_HALT));
    chk("t5_ready", 32'(enq_ready), 32'd0);
    chk("t5_quiet", 32'({cpu_load, cpu_s}), 32'd0);
    cpu_w = 1'b1;
    tick();
    chk("t5_halt_sticky", 32'(dbg_state), 32'(S_HALT));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t5_rst_err", 32'(err), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(enq_ready), 32'd1);
    chk("t5_rst_count", 32'(issued_count), 32'd0);

    // Reset mid-handshake (WAIT_HI) with 3 entries queued
    cpu_w = 1'b0;
    enq(K_ADD, 3'd1, 3'd2, 3'd3, 2'd0, 8'd0);
    enq(K_CMP, 3'd1, 3'd0, 3'd3, 2'd0, 8'd0);
    enq(K_MVN, 3'd0, 3'd2, 3'd3, 2'd1, 8'd0);
    cpu_w = 1'b1;
    wait_load();
    tick();
    tick();
    cpu_w = 1'b0;
    tick();
    chk("t6_in_wait_hi", 32'(dbg_state), 32'(S_WAIT_HI));
    reset = 1'b0;
    tick();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_count", 32'(issued_count), 32'd0);
    chk("t6_quiet", 32'({cpu_load, cpu_s}), 32'd0);
    chk("t6_cpu_in", 32'(cpu_in), 32'd0);
    reset = 1'b1;
    cpu_w = 1'b1;
    tick();
    chk("t6_empty_no_issue", 32'({busy, cpu_load}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
